// File: rtl/cache_def.sv
// Shared definitions for the direct-mapped accumulator cache: controller
// states and request opcodes. Widths stay on the modules as parameters.
package cache_def;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_WRITE_BACK,
        ST_ALLOCATE,
        ST_RESPOND
    } state_e;

    // Opcode 11 is reserved and executes as a plain read.
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_ACCUM = 2'b01,
        OP_RCLR  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

endpackage

// File: rtl/dm_accum_ram.sv
// Line storage for dm_accum_cache: tag and data arrays with asynchronous read
// and a single synchronous write port; valid/dirty kept in flops.
module dm_accum_ram #(
    parameter int INDEX_W = 10,
    parameter int TAG_W   = 22,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [DATA_W-1:0]  rd_data_o,
    output logic               rd_valid_o,
    output logic               rd_dirty_o,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [DATA_W-1:0]  wr_data_i,
    input  logic               wr_dirty_i
);

    localparam int DEPTH = 1 << INDEX_W;

    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  dirty_q;

    // NOTE: the arrays carry no reset; a cleared valid bit is enough to make
    // their contents unreachable, so they map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_mem[wr_index_i]  <= wr_tag_i;
            data_mem[wr_index_i] <= wr_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
            dirty_q[wr_index_i] <= wr_dirty_i;
        end
    end

    assign rd_tag_o   = tag_mem[rd_index_i];
    assign rd_data_o  = data_mem[rd_index_i];
    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_dirty_o = dirty_q[rd_index_i];

endmodule

// File: rtl/dm_accum_cache.sv
// Direct-mapped write-back cache of saturating accumulators, one per line,
// with a single outstanding request and a level-handshake backing memory.
module dm_accum_cache
    import cache_def::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                INDEX_W   = 10,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] SAT_LIMIT = 'hFFAA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_sat,
    output logic              mem_req_valid,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_resp_ready,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int TAG_W = ADDR_W - INDEX_W;

    state_e              state_q, state_d;
    op_e                 op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                first_q;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic                res_sat_q, res_sat_d;
    logic [31:0]         hit_cnt_q, miss_cnt_q;

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;
    logic [TAG_W-1:0]    rd_tag;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_valid, rd_dirty;
    logic                hit;
    logic [DATA_W:0]     sum;
    logic                over;
    logic                wr_en, wr_dirty;
    logic [DATA_W-1:0]   wr_data;

    assign idx  = addr_q[INDEX_W-1:0];
    assign tag  = addr_q[ADDR_W-1:INDEX_W];
    assign hit  = rd_valid && (rd_tag == tag);
    assign sum  = {1'b0, rd_data} + {1'b0, data_q};
    assign over = sum > {1'b0, SAT_LIMIT};

    dm_accum_ram #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_ram (
        .clk        (clk),
        .rst        (rst),
        .rd_index_i (idx),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .wr_en_i    (wr_en),
        .wr_index_i (idx),
        .wr_tag_i   (tag),
        .wr_data_i  (wr_data),
        .wr_dirty_i (wr_dirty)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        res_data_d    = res_data_q;
        res_sat_d     = res_sat_q;
        wr_en         = 1'b0;
        wr_dirty      = 1'b1;
        wr_data       = rd_data;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = addr_q;
        mem_req_data  = rd_data;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) state_d = ST_COMPARE;
            end
            ST_COMPARE: begin
                if (hit) begin
                    state_d    = ST_RESPOND;
                    res_data_d = rd_data;
                    res_sat_d  = 1'b0;
                    if (op_q == OP_ACCUM) begin
                        wr_en      = 1'b1;
                        wr_data    = over ? SAT_LIMIT : sum[DATA_W-1:0];
                        res_data_d = wr_data;
                        res_sat_d  = over;
                    end else if (op_q == OP_RCLR) begin
                        wr_en   = 1'b1;
                        wr_data = '0;
                    end
                end else if (rd_valid && rd_dirty) begin
                    state_d = ST_WRITE_BACK;
                end else begin
                    state_d = ST_ALLOCATE;
                end
            end
            ST_WRITE_BACK: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {rd_tag, idx};
                if (mem_resp_ready) state_d = ST_ALLOCATE;
            end
            ST_ALLOCATE: begin
                mem_req_valid = 1'b1;
                if (mem_resp_ready) begin
                    wr_en    = 1'b1;
                    wr_data  = mem_resp_data;
                    wr_dirty = 1'b0;
                    state_d  = ST_COMPARE;
                end
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_READ;
            addr_q     <= '0;
            data_q     <= '0;
            first_q    <= 1'b0;
            res_data_q <= '0;
            res_sat_q  <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            res_data_q <= res_data_d;
            res_sat_q  <= res_sat_d;
            if (state_q == ST_IDLE && req_valid) begin
                op_q    <= op_e'(req_op);
                addr_q  <= req_addr;
                data_q  <= req_data;
                first_q <= 1'b1;
            end
            // Only the first lookup of a request is a statistic; the re-compare
            // after a fill is always a hit and must not be counted.
            if (state_q == ST_COMPARE && first_q) begin
                first_q <= 1'b0;
                if (hit && hit_cnt_q != '1)        hit_cnt_q  <= hit_cnt_q + 32'd1;
                else if (!hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign res_valid = (state_q == ST_RESPOND);
    assign res_data  = res_data_q;
    assign res_sat   = res_sat_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_dm_accum_cache.sv
// Self-checking bench for dm_accum_cache: directed scenarios followed by random
// traffic, all checked against a transaction-level cache/memory model.
module tb_dm_accum_cache;

    localparam int          ADDR_W = 32;
    localparam int          INDEX_W = 10;
    localparam int          DATA_W = 32;
    localparam logic [31:0] SAT    = 32'hFFAA;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr, req_data;
    logic        res_valid, res_sat;
    logic [31:0] res_data;
    logic        mem_req_valid, mem_req_rw;
    logic [31:0] mem_req_addr, mem_req_data;
    logic        mem_resp_ready;
    logic [31:0] mem_resp_data;
    logic [31:0] hit_cnt, miss_cnt;

    dm_accum_cache #(
        .ADDR_W    (ADDR_W),
        .INDEX_W   (INDEX_W),
        .DATA_W    (DATA_W),
        .SAT_LIMIT (SAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .res_sat        (res_sat),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_data  (mem_resp_data),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one line per index plus a sparse backing memory.
    bit          m_valid [1024];
    bit          m_dirty [1024];
    logic [21:0] m_tag   [1024];
    logic [31:0] m_data  [1024];
    logic [31:0] backing [int unsigned];
    int unsigned m_hit, m_miss;

    // Observations of the last transaction, used by the literal pins.
    logic [31:0] last_res, wb_addr_seen, wb_data_seen, fill_addr_seen;
    bit          last_sat, last_hit;
    int          last_lat;
    bit          running = 1'b0;

    // Untouched memory holds tag * 0x3001, so tag 0 starts at zero.
    function automatic logic [31:0] back_rd(input logic [31:0] a);
        if (backing.exists(a)) return backing[a];
        return (a >> INDEX_W) * 32'h3001;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hit  = 0;
        m_miss = 0;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        int              idx, delay, fill_k;
        logic [21:0]     tg;
        bit              hit, exp_wb, wr, sat, got, in_phase, phase_rw, wb_done, fill_done;
        logic [31:0]     exp_wb_addr, exp_wb_data, cur, nv;
        longint unsigned s;

        idx         = int'(addr[9:0]);
        tg          = addr[31:10];
        hit         = m_valid[idx] && (m_tag[idx] == tg);
        exp_wb      = !hit && m_valid[idx] && m_dirty[idx];
        exp_wb_addr = {m_tag[idx], addr[9:0]};
        exp_wb_data = m_data[idx];
        cur         = hit ? m_data[idx] : back_rd(addr);
        nv  = cur;
        sat = 1'b0;
        wr  = 1'b0;
        if (op == 2'b01) begin
            s = 64'(cur) + 64'(data);
            if (s > 64'(SAT)) begin
                nv  = SAT;
                sat = 1'b1;
            end else begin
                nv = s[31:0];
            end
            wr = 1'b1;
        end else if (op == 2'b10) begin
            nv = 32'h0;
            wr = 1'b1;
        end

        @(negedge clk);
        check("ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = data;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data  = $urandom;

        got = 0; in_phase = 0; phase_rw = 0; wb_done = 0; fill_done = 0;
        delay = 0; fill_k = 0; last_lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (res_valid) begin
                got      = 1'b1;
                last_lat = k;
                break;
            end
            check("busy_not_ready", req_ready, 1'b0);
            if (mem_req_valid) begin
                if (!in_phase || mem_req_rw != phase_rw) begin
                    in_phase = 1'b1;
                    phase_rw = mem_req_rw;
                    delay    = int'($urandom_range(0, 3));
                    check("no_mem_on_hit", hit, 1'b0);
                    if (mem_req_rw) begin
                        check("wb_expected", exp_wb, 1'b1);
                        check("wb_addr", mem_req_addr, exp_wb_addr);
                        check("wb_data", mem_req_data, exp_wb_data);
                        wb_addr_seen = mem_req_addr;
                        wb_data_seen = mem_req_data;
                        wb_done      = 1'b1;
                    end else begin
                        check("fill_addr", mem_req_addr, addr);
                        check("fill_after_wb", wb_done, exp_wb);
                        fill_addr_seen = mem_req_addr;
                        fill_done      = 1'b1;
                    end
                end
                if (delay == 0) begin
                    mem_resp_ready = 1'b1;
                    mem_resp_data  = mem_req_rw ? $urandom : back_rd(addr);
                    in_phase       = 1'b0;
                    if (!mem_req_rw) fill_k = k;
                end else begin
                    delay--;
                    mem_resp_ready = 1'b0;
                    mem_resp_data  = $urandom;
                end
            end else begin
                // Memory ready outside a memory phase must be ignored.
                in_phase       = 1'b0;
                mem_resp_ready = 1'($urandom_range(0, 1));
                mem_resp_data  = $urandom;
            end
        end
        mem_resp_ready = 1'b0;

        if (!got) begin
            check("response_timeout", 1'b0, 1'b1);
            return;
        end
        check("res_data", res_data, nv == 32'h0 && op == 2'b10 ? cur : (op == 2'b01 ? nv : cur));
        check("res_sat", res_sat, sat);
        check("res_latency", last_lat, hit ? 2 : fill_k + 2);
        check("wb_occurred", wb_done, exp_wb);
        check("fill_occurred", fill_done, !hit);

        last_res = res_data;
        last_sat = res_sat;
        last_hit = hit;
        if (exp_wb) backing[exp_wb_addr] = exp_wb_data;
        m_dirty[idx] = hit ? (m_dirty[idx] | wr) : wr;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_data[idx]  = nv;
        if (hit) m_hit++;
        else     m_miss++;

        @(negedge clk);
        check("res_valid_pulse", res_valid, 1'b0);
        check("res_data_hold", res_data, last_res);
        check("res_sat_hold", res_sat, last_sat);
        check("ready_after", req_ready, 1'b1);
        check("hit_cnt", hit_cnt, m_hit);
        check("miss_cnt", miss_cnt, m_miss);
    endtask

    // Cycle-by-cycle properties that hold in every state.
    always @(negedge clk) begin
        if (running && rst) begin
            check("ready_vs_mem", mem_req_valid && req_ready, 1'b0);
            check("res_vs_mem", res_valid && mem_req_valid, 1'b0);
        end
    end

    initial begin
        bit seen;
        rst            = 1'b0;
        req_valid      = 1'b0;
        req_op         = 2'b00;
        req_addr       = '0;
        req_data       = '0;
        mem_resp_ready = 1'b0;
        mem_resp_data  = '0;
        model_reset();

        #12;
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_sat", res_sat, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        @(negedge clk);
        rst     = 1'b1;
        running = 1'b1;
        @(negedge clk);
        check("rst_ready", req_ready, 1'b1);

        // Cold miss, fill of zero, accumulate.
        do_req(2'b01, 32'h5, 32'h10);
        check("pin_first_res", last_res, 32'h10);
        check("pin_first_miss", miss_cnt, 1);
        check("pin_first_fill", fill_addr_seen, 32'h5);

        do_req(2'b01, 32'h5, 32'h20);
        check("pin_hit_res", last_res, 32'h30);
        check("pin_hit_cnt", hit_cnt, 1);
        check("pin_hit_lat", last_lat, 2);

        do_req(2'b10, 32'h5, 32'h0);
        check("pin_rclr_res", last_res, 32'h30);
        do_req(2'b00, 32'h5, 32'h0);
        check("pin_after_clr", last_res, 32'h0);

        do_req(2'b01, 32'h5, 32'hFF00);
        check("pin_ff00", last_res, 32'hFF00);
        do_req(2'b01, 32'h5, 32'h100);
        check("pin_sat_res", last_res, 32'hFFAA);
        check("pin_sat_flag", last_sat, 1'b1);

        // Conflict on index 5 evicts the dirty line.
        do_req(2'b00, 32'h405, 32'h0);
        check("pin_wb_addr", wb_addr_seen, 32'h5);
        check("pin_wb_data", wb_data_seen, 32'hFFAA);
        check("pin_fill_405", fill_addr_seen, 32'h405);
        check("pin_405_res", last_res, 32'h3001);

        // Reset while the fill for addr 0x5 is outstanding.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_addr  = 32'h5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        seen      = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_req_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort_alloc_seen", seen, 1'b1);
        check("abort_alloc_rw", mem_req_rw, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("abort_mem_drop", mem_req_valid, 1'b0);
        check("abort_cnt", miss_cnt, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_res", res_valid, 1'b0);
        end
        rst = 1'b1;
        model_reset();
        do_req(2'b00, 32'h5, 32'h0);
        check("pin_post_rst_miss", last_hit, 1'b0);
        check("pin_post_rst_cnt", miss_cnt, 1);
        check("pin_post_rst_res", last_res, 32'hFFAA);

        // Random traffic over a few conflicting lines.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, d;
            logic [1:0]  sel;
            if ($urandom_range(0, 7) == 0) begin
                a = $urandom;
            end else begin
                sel = 2'($urandom_range(0, 3));
                a   = {20'h0, (sel == 2'd3) ? 2'd1 : 2'd0, sel == 2'd3 ? 1'b0 : sel[1],
                       sel == 2'd3 ? 1'b1 : sel[0], 10'(5 + $urandom_range(0, 2))};
            end
            case ($urandom_range(0, 3))
                0:       d = $urandom & 32'hFF;
                1:       d = $urandom & 32'h7FFF;
                2:       d = $urandom;
                default: d = 32'h0;
            endcase
            do_req(2'($urandom_range(0, 3)), a, d);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                mem_resp_ready = 1'($urandom_range(0, 1));
            end
            mem_resp_ready = 1'b0;
        end

        running = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_accum_cache.md
DM_ACCUM_CACHE -- requirements
Module: dm_accum_cache

Interface
REQ-001 Parameter ADDR_W, 32, client-ID/address width.
REQ-002 Parameter INDEX_W, 10, index bits; depth = 2**INDEX_W lines, one DATA_W accumulator per line.
REQ-003 Parameter DATA_W, 32, accumulator width.
REQ-004 Parameter SAT_LIMIT, 'hFFAA, saturation ceiling (DATA_W wide).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  block can accept a request.
REQ-009 req_op  in  2  00 read, 01 accumulate, 10 read-clear, 11 reserved (treated as read).
REQ-010 req_addr  in  ADDR_W  client ID; tag = [ADDR_W-1:INDEX_W], index = [INDEX_W-1:0].
REQ-011 req_data  in  DATA_W  addend for accumulate.
REQ-012 res_valid  out  1  one-cycle response strobe.
REQ-013 res_data  out  DATA_W  response value.
REQ-014 res_sat  out  1  accumulate was clamped.
REQ-015 mem_req_valid  out  1  backing-memory request, level, held until mem_resp_ready.
REQ-016 mem_req_rw  out  1  1 write-back, 0 fill.
REQ-017 mem_req_addr  out  ADDR_W  memory address.
REQ-018 mem_req_data  out  DATA_W  write-back data.
REQ-019 mem_resp_ready  in  1  memory completed current request.
REQ-020 mem_resp_data  in  DATA_W  fill data.
REQ-021 hit_cnt, miss_cnt  out  32 each  statistics counters.

Function
REQ-022 States IDLE, COMPARE, WRITE_BACK, ALLOCATE, RESPOND; req_ready = 1 only in IDLE.
REQ-023 Handshake req_valid&&req_ready latches op/addr/data and moves IDLE->COMPARE; requests while busy are not accepted and shall be held by the requester.
REQ-024 COMPARE hit (valid && tag match): perform op, go RESPOND; res_valid high in the RESPOND cycle, i.e. hit latency 2 cycles after acceptance, then IDLE.
REQ-025 Accumulate: sum formed in DATA_W+1 bits; if sum > SAT_LIMIT store SAT_LIMIT and res_sat=1, else store sum; res_data = stored value; line dirty.
REQ-026 Read: res_data = stored value, line unchanged. Read-clear: res_data = old value, store 0, line dirty.
REQ-027 COMPARE miss, victim valid&&dirty: go WRITE_BACK driving rw=1, addr={victim tag,index}, data=victim data.
REQ-028 COMPARE miss, victim invalid or clean: go ALLOCATE driving rw=0, addr=latched req_addr.
REQ-029 WRITE_BACK on mem_resp_ready -> ALLOCATE (next cycle issues fill); ALLOCATE on mem_resp_ready writes mem_resp_data, new tag, valid=1, dirty=0, -> COMPARE (guaranteed hit).
REQ-030 mem_resp_ready outside WRITE_BACK/ALLOCATE is ignored; mem_req_valid = 0 in IDLE, COMPARE, RESPOND.
REQ-031 hit_cnt increments once per request hitting on first compare, miss_cnt once per request missing on first compare; re-compare after fill counts nothing; both saturate at all-ones.
REQ-032 res_data/res_sat hold last values when res_valid=0.

Reset
REQ-033 Assertion of rst: state IDLE, all valid and dirty bits 0, counters 0, res_valid/res_sat/mem_req_valid 0, req_ready 1 after release.
REQ-034 Reset mid-transaction abandons it: no response, no write to storage, mem_req_valid drops asynchronously; data/tag RAM contents are not cleared.

Structure
REQ-035 State enum and op encoding belong in the shared cache_def package; widths stay module parameters.
REQ-036 Storage is one sub-module dm_accum_ram: tag+data array, asynchronous read, synchronous write, valid/dirty as flop vectors with async clear.

Verification
REQ-037 Reset, accumulate 0x10 to addr 0x5 -> miss_cnt=1, fill of 0x0, res_data=0x10 on cycle after COMPARE re-hit.
REQ-038 Accumulate 0x20 to addr 0x5 again -> hit, res_valid 2 cycles after accept, res_data=0x30, hit_cnt=1.
REQ-039 Addr 0x5 holds 0xFF00, accumulate 0x100 -> res_data=0xFFAA, res_sat=1.
REQ-040 Dirty line addr 0x5, access addr 0x405 -> write-back rw=1 addr=0x5 data=old value, then fill addr=0x405.
REQ-041 Read-clear addr 0x5 holding 0x30 -> res_data=0x30, subsequent read -> 0x0.
REQ-042 rst low during ALLOCATE -> mem_req_valid 0 immediately, no res_valid, subsequent read of same addr misses.
